// File: rtl/shop_inv_v.sv
// rtl/shop_inv_v.sv - token-driven shop controller with user table, permissions and item inventory
// Each i_rdy cycle consumes one ASCII token and registers a prompt or terminal message on o_a.
module shop_inv_v #(
   parameter int I_A_NUM_ASCII_CHARS = 7,
   parameter int O_A_NUM_ASCII_CHARS = 9,
   parameter int I_U_NUM_BITS        = 4,
   parameter int MAX_USERS           = 5,
   parameter int MAX_ITEMS           = 4,
   parameter     ADMIN_USERNAME      = "Adm",
   parameter     ADMIN_PASSWORD      = "123",
   localparam int I_A_NUM_BITS       = 8 * I_A_NUM_ASCII_CHARS,
   localparam int O_A_NUM_BITS       = 8 * O_A_NUM_ASCII_CHARS
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_rdy,
   input  logic [I_U_NUM_BITS-1:0] i_u,
   input  logic [I_A_NUM_BITS-1:0] i_a,
   output logic [O_A_NUM_BITS-1:0] o_a,
   output logic                    o_valid,
   output logic                    o_err
);

   localparam int AW  = I_A_NUM_BITS;
   localparam int DW  = O_A_NUM_BITS;
   localparam int QW  = I_U_NUM_BITS;
   localparam int UW  = (MAX_USERS > 1) ? $clog2(MAX_USERS) : 1;
   localparam int ITW = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;

   localparam logic [AW-1:0] L_ADMIN_NAME = AW'(ADMIN_USERNAME);
   localparam logic [AW-1:0] L_ADMIN_PASS = AW'(ADMIN_PASSWORD);

   localparam logic [AW-1:0] K_LOGIN   = AW'("Login");
   localparam logic [AW-1:0] K_LOGOUT  = AW'("Logout");
   localparam logic [AW-1:0] K_ADDUSR  = AW'("AddUsr");
   localparam logic [AW-1:0] K_DELUSR  = AW'("DelUsr");
   localparam logic [AW-1:0] K_ADDITEM = AW'("AddItem");
   localparam logic [AW-1:0] K_DELITEM = AW'("DelItem");
   localparam logic [AW-1:0] K_BUY     = AW'("Buy");
   localparam logic [AW-1:0] K_SELLER  = AW'("SELLER");
   localparam logic [AW-1:0] K_BUYER   = AW'("BUYER");

   localparam logic [DW-1:0] M_CMD       = DW'("Cmd?");
   localparam logic [DW-1:0] M_USER      = DW'("User?");
   localparam logic [DW-1:0] M_PASS      = DW'("Pass?");
   localparam logic [DW-1:0] M_PERM      = DW'("Perm?");
   localparam logic [DW-1:0] M_ITEM      = DW'("Item?");
   localparam logic [DW-1:0] M_QTY       = DW'("Qty?");
   localparam logic [DW-1:0] M_LOGGEDIN  = DW'("LoggedIn");
   localparam logic [DW-1:0] M_LOGGEDOUT = DW'("LoggedOut");
   localparam logic [DW-1:0] M_USRADDED  = DW'("UsrAdded");
   localparam logic [DW-1:0] M_USRDEL    = DW'("UsrDel");
   localparam logic [DW-1:0] M_ITEMADDED = DW'("ItemAdded");
   localparam logic [DW-1:0] M_ITEMDEL   = DW'("ItemDel");
   localparam logic [DW-1:0] M_BOUGHT    = DW'("Bought");
   localparam logic [DW-1:0] M_INVALCMD  = DW'("InvalCmd");
   localparam logic [DW-1:0] M_INVALPERM = DW'("InvalPerm");
   localparam logic [DW-1:0] M_NOUSER    = DW'("NoUser");
   localparam logic [DW-1:0] M_BADPASS   = DW'("BadPass");
   localparam logic [DW-1:0] M_USRTAKEN  = DW'("UsrTaken");
   localparam logic [DW-1:0] M_USRFULL   = DW'("UsrFull");
   localparam logic [DW-1:0] M_BADTYPE   = DW'("BadType");
   localparam logic [DW-1:0] M_ITEMFULL  = DW'("ItemFull");
   localparam logic [DW-1:0] M_NOITEM    = DW'("NoItem");
   localparam logic [DW-1:0] M_NOTOWNER  = DW'("NotOwner");
   localparam logic [DW-1:0] M_BADQTY    = DW'("BadQty");
   localparam logic [DW-1:0] M_NOSTOCK   = DW'("NoStock");

   typedef enum logic [1:0] {P_ADMIN, P_SELLER, P_BUYER} perm_t;

   typedef enum logic [3:0] {
      S_CMD, S_L_USER, S_L_PASS, S_A_USER, S_A_PASS, S_A_PERM,
      S_D_USER, S_I_NAME, S_I_QTY, S_X_NAME, S_B_NAME, S_B_QTY
   } state_t;

   state_t               r_state;
   logic                 r_logged;
   logic [UW-1:0]        r_sess;
   logic [UW-1:0]        r_slot;
   logic [ITW-1:0]       r_item;
   logic [AW-1:0]        r_name;
   logic [AW-1:0]        r_pass;

   logic [MAX_USERS-1:0] r_u_valid;
   logic [AW-1:0]        r_u_name [MAX_USERS];
   logic [AW-1:0]        r_u_pass [MAX_USERS];
   perm_t                r_u_perm [MAX_USERS];

   logic [MAX_ITEMS-1:0] r_i_valid;
   logic [AW-1:0]        r_i_name  [MAX_ITEMS];
   logic [UW-1:0]        r_i_owner [MAX_ITEMS];
   logic [QW-1:0]        r_i_qty   [MAX_ITEMS];

   logic                 w_u_hit, w_u_full;
   logic [UW-1:0]        w_u_idx, w_u_free;
   logic                 w_i_hit, w_i_full;
   logic [ITW-1:0]       w_i_idx, w_i_free;
   logic [AW-1:0]        w_i_key;
   logic                 w_key;
   perm_t                w_sess_perm;
   logic [QW:0]          w_sum;
   logic [QW-1:0]        w_sat;

   assign w_sess_perm = r_u_perm[r_sess];
   assign w_key = (i_a == K_LOGIN)   || (i_a == K_LOGOUT)  || (i_a == K_ADDUSR) ||
                  (i_a == K_DELUSR)  || (i_a == K_ADDITEM) || (i_a == K_DELITEM) ||
                  (i_a == K_BUY);

   // Descending scans leave the lowest-numbered match / free slot in the result.
   always_comb begin
      w_u_hit  = 1'b0;
      w_u_idx  = '0;
      w_u_full = 1'b1;
      w_u_free = '0;
      for (int k = MAX_USERS - 1; k >= 0; k--) begin
         if (r_u_valid[k] && (r_u_name[k] == i_a)) begin
            w_u_hit = 1'b1;
            w_u_idx = UW'(k);
         end
         if (!r_u_valid[k]) begin
            w_u_full = 1'b0;
            w_u_free = UW'(k);
         end
      end
   end

   // In I_QTY the item name was latched on the previous token.
   assign w_i_key = (r_state == S_I_QTY) ? r_name : i_a;

   always_comb begin
      w_i_hit  = 1'b0;
      w_i_idx  = '0;
      w_i_full = 1'b1;
      w_i_free = '0;
      for (int k = MAX_ITEMS - 1; k >= 0; k--) begin
         if (r_i_valid[k] && (r_i_name[k] == w_i_key)) begin
            w_i_hit = 1'b1;
            w_i_idx = ITW'(k);
         end
         if (!r_i_valid[k]) begin
            w_i_full = 1'b0;
            w_i_free = ITW'(k);
         end
      end
   end

   assign w_sum = {1'b0, r_i_qty[w_i_idx]} + {1'b0, i_u};
   assign w_sat = w_sum[QW] ? {QW{1'b1}} : w_sum[QW-1:0];

   function automatic logic f_is_err(input logic [DW-1:0] m);
      return (m == M_INVALCMD) || (m == M_INVALPERM) || (m == M_NOUSER)   ||
             (m == M_BADPASS)  || (m == M_USRTAKEN)  || (m == M_USRFULL)  ||
             (m == M_BADTYPE)  || (m == M_ITEMFULL)  || (m == M_NOITEM)   ||
             (m == M_NOTOWNER) || (m == M_BADQTY)    || (m == M_NOSTOCK);
   endfunction

   assign o_err = f_is_err(o_a);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state  <= S_CMD;
         r_logged <= 1'b0;
         r_sess   <= '0;
         r_slot   <= '0;
         r_item   <= '0;
         r_name   <= '0;
         r_pass   <= '0;
         o_a      <= M_CMD;
         o_valid  <= 1'b0;
         for (int k = 0; k < MAX_USERS; k++) begin
            r_u_valid[k] <= (k == 0);
            r_u_name[k]  <= (k == 0) ? L_ADMIN_NAME : '0;
            r_u_pass[k]  <= (k == 0) ? L_ADMIN_PASS : '0;
            r_u_perm[k]  <= P_ADMIN;
         end
         for (int k = 0; k < MAX_ITEMS; k++) begin
            r_i_valid[k] <= 1'b0;
            r_i_name[k]  <= '0;
            r_i_owner[k] <= '0;
            r_i_qty[k]   <= '0;
         end
      end else begin
         o_valid <= i_rdy;
         if (i_rdy) begin
            r_state <= S_CMD;
            case (r_state)
               S_CMD: begin
                  if (!r_logged) begin
                     if (i_a == K_LOGIN) begin
                        r_state <= S_L_USER;
                        o_a     <= M_USER;
                     end else begin
                        o_a <= w_key ? M_INVALPERM : M_INVALCMD;
                     end
                  end else if (i_a == K_LOGOUT) begin
                     r_logged <= 1'b0;
                     o_a      <= M_LOGGEDOUT;
                  end else if ((i_a == K_ADDUSR) && (w_sess_perm == P_ADMIN)) begin
                     if (w_u_full) begin
                        o_a <= M_USRFULL;
                     end else begin
                        r_state <= S_A_USER;
                        o_a     <= M_USER;
                     end
                  end else if ((i_a == K_DELUSR) && (w_sess_perm == P_ADMIN)) begin
                     r_state <= S_D_USER;
                     o_a     <= M_USER;
                  end else if ((i_a == K_ADDITEM) && (w_sess_perm == P_SELLER)) begin
                     r_state <= S_I_NAME;
                     o_a     <= M_ITEM;
                  end else if ((i_a == K_DELITEM) && (w_sess_perm == P_SELLER)) begin
                     r_state <= S_X_NAME;
                     o_a     <= M_ITEM;
                  end else if ((i_a == K_BUY) && (w_sess_perm == P_BUYER)) begin
                     r_state <= S_B_NAME;
                     o_a     <= M_ITEM;
                  end else begin
                     o_a <= w_key ? M_INVALPERM : M_INVALCMD;
                  end
               end
               S_L_USER: begin
                  if (w_u_hit) begin
                     r_slot  <= w_u_idx;
                     r_state <= S_L_PASS;
                     o_a     <= M_PASS;
                  end else begin
                     o_a <= M_NOUSER;
                  end
               end
               S_L_PASS: begin
                  if (i_a == r_u_pass[r_slot]) begin
                     r_logged <= 1'b1;
                     r_sess   <= r_slot;
                     o_a      <= M_LOGGEDIN;
                  end else begin
                     o_a <= M_BADPASS;
                  end
               end
               S_A_USER: begin
                  if (w_u_hit) begin
                     o_a <= M_USRTAKEN;
                  end else begin
                     r_name  <= i_a;
                     r_state <= S_A_PASS;
                     o_a     <= M_PASS;
                  end
               end
               S_A_PASS: begin
                  r_pass  <= i_a;
                  r_state <= S_A_PERM;
                  o_a     <= M_PERM;
               end
               S_A_PERM: begin
                  if ((i_a == K_SELLER) || (i_a == K_BUYER)) begin
                     r_u_valid[w_u_free] <= 1'b1;
                     r_u_name[w_u_free]  <= r_name;
                     r_u_pass[w_u_free]  <= r_pass;
                     r_u_perm[w_u_free]  <= (i_a == K_SELLER) ? P_SELLER : P_BUYER;
                     o_a                 <= M_USRADDED;
                  end else begin
                     o_a <= M_BADTYPE;
                  end
               end
               S_D_USER: begin
                  if (i_a == L_ADMIN_NAME) begin
                     o_a <= M_INVALPERM;
                  end else if (!w_u_hit) begin
                     o_a <= M_NOUSER;
                  end else begin
                     r_u_valid[w_u_idx] <= 1'b0;
                     for (int k = 0; k < MAX_ITEMS; k++) begin
                        if (r_i_valid[k] && (r_i_owner[k] == w_u_idx)) begin
                           r_i_valid[k] <= 1'b0;
                        end
                     end
                     o_a <= M_USRDEL;
                  end
               end
               S_I_NAME: begin
                  r_name  <= i_a;
                  r_state <= S_I_QTY;
                  o_a     <= M_QTY;
               end
               S_I_QTY: begin
                  if (w_i_hit) begin
                     if (r_i_owner[w_i_idx] == r_sess) begin
                        r_i_qty[w_i_idx] <= w_sat;
                        o_a              <= M_ITEMADDED;
                     end else begin
                        o_a <= M_NOTOWNER;
                     end
                  end else if (w_i_full) begin
                     o_a <= M_ITEMFULL;
                  end else begin
                     r_i_valid[w_i_free] <= 1'b1;
                     r_i_name[w_i_free]  <= r_name;
                     r_i_owner[w_i_free] <= r_sess;
                     r_i_qty[w_i_free]   <= i_u;
                     o_a                 <= M_ITEMADDED;
                  end
               end
               S_X_NAME: begin
                  if (!w_i_hit) begin
                     o_a <= M_NOITEM;
                  end else if (r_i_owner[w_i_idx] != r_sess) begin
                     o_a <= M_NOTOWNER;
                  end else begin
                     r_i_valid[w_i_idx] <= 1'b0;
                     o_a                <= M_ITEMDEL;
                  end
               end
               S_B_NAME: begin
                  if (w_i_hit) begin
                     r_item  <= w_i_idx;
                     r_state <= S_B_QTY;
                     o_a     <= M_QTY;
                  end else begin
                     o_a <= M_NOITEM;
                  end
               end
               S_B_QTY: begin
                  if (i_u == '0) begin
                     o_a <= M_BADQTY;
                  end else if (i_u > r_i_qty[r_item]) begin
                     o_a <= M_NOSTOCK;
                  end else begin
                     r_i_qty[r_item] <= r_i_qty[r_item] - i_u;
                     o_a             <= M_BOUGHT;
                  end
               end
               default: o_a <= M_INVALCMD;
            endcase
         end
      end
   end

endmodule
